// File: rtl/ysyx_041461_exe_muldiv_pkg.sv
// Shared encodings and decode helpers for the EXE-stage RV64M multiply/divide unit.
// Holds the op codes, the FSM states and the W-result sign extension.
package ysyx_041461_exe_muldiv_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 6;

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic op_is_w(input logic [3:0] op);
    return (op >= OP_MULW) && (op <= OP_REMUW);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

endpackage

// File: rtl/ysyx_041461_exe_muldiv.sv
// Iterative RV64M multiply/divide: 64-cycle shift-add multiply and restoring divide
// on sign-magnitude operands, stalling EXE until a one-cycle done pulse.
module ysyx_041461_exe_muldiv
  import ysyx_041461_exe_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            muldiv_valid,
  input  logic [3:0]      muldiv_op,
  input  logic [XLEN-1:0] muldiv_src1,
  input  logic [XLEN-1:0] muldiv_src2,
  input  logic            muldiv_flush,
  output logic            muldiv_busy,
  output logic            muldiv_done,
  output logic [XLEN-1:0] muldiv_result
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         op_q;
  logic [XLEN-1:0]    a_q, lo_q, result_q;
  logic [XLEN:0]      hi_q;
  logic               qneg_q, rneg_q, spec_q;

  logic               is_w, w_zext, s1_sgn, s2_sgn, is_div, rsvd;
  logic               neg1, neg2, div0, ovf, special, accept;
  logic [XLEN-1:0]    x1, x2, m1, m2, spec_val;

  // Operand preparation and special-case detection on the incoming instruction.
  always_comb begin
    is_w    = op_is_w(muldiv_op);
    w_zext  = (muldiv_op == OP_DIVUW) || (muldiv_op == OP_REMUW);
    is_div  = op_is_div(muldiv_op);
    rsvd    = muldiv_op > OP_REMUW;
    s1_sgn  = muldiv_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    s2_sgn  = muldiv_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    x1      = muldiv_src1;
    x2      = muldiv_src2;
    if (is_w) begin
      x1 = w_zext ? {32'b0, muldiv_src1[31:0]} : sext32(muldiv_src1[31:0]);
      x2 = w_zext ? {32'b0, muldiv_src2[31:0]} : sext32(muldiv_src2[31:0]);
    end
    neg1    = s1_sgn & x1[XLEN-1];
    neg2    = s2_sgn & x2[XLEN-1];
    m1      = neg1 ? -x1 : x1;
    m2      = neg2 ? -x2 : x2;
    div0    = is_div & (x2 == '0);
    ovf     = is_div & s2_sgn & (x2 == '1)
            & (x1 == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special = div0 | ovf | rsvd;
    spec_val = '0;
    if (div0)     spec_val = op_is_rem(muldiv_op) ? x1 : '1;
    else if (ovf) spec_val = op_is_rem(muldiv_op) ? '0 : x1;
    accept  = (state_q == S_IDLE) & muldiv_valid & ~muldiv_flush;
  end

  logic [XLEN:0]   mul_sum, div_shl;
  logic            div_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, rem, raw, res_c;

  // One iteration step of each algorithm plus final sign/width fix-up.
  always_comb begin
    mul_sum = hi_q + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shl = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    div_ge  = div_shl >= {1'b0, a_q};
    prod    = {hi_q[XLEN-1:0], lo_q};
    if (qneg_q) prod = -prod;
    quot    = qneg_q ? -lo_q : lo_q;
    rem     = rneg_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];
    unique case (op_q)
      OP_MUL, OP_MULW:                  raw = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:     raw = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU, OP_DIVW, OP_DIVUW: raw = quot;
      OP_REM, OP_REMU, OP_REMW, OP_REMUW: raw = rem;
      default:                          raw = '0;
    endcase
    if (spec_q) raw = lo_q;
    res_c = op_is_w(op_q) ? sext32(raw[31:0]) : raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (muldiv_flush) state_d = S_IDLE;
  end

  always_comb begin
    muldiv_busy   = accept | (state_q == S_CALC);
    muldiv_done   = (state_q == S_DONE) & ~muldiv_flush;
    muldiv_result = muldiv_done ? res_c : result_q;
  end

  // Shared operand/accumulator registers: hi:lo is the product or remainder:quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
    end else if (muldiv_flush) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (muldiv_valid) begin
          cnt_q  <= '0;
          op_q   <= muldiv_op;
          a_q    <= m2;
          hi_q   <= '0;
          lo_q   <= special ? spec_val : m1;
          qneg_q <= neg1 ^ neg2;
          rneg_q <= neg1;
          spec_q <= special;
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (op_is_div(op_q)) begin
            hi_q <= div_ge ? (div_shl - {1'b0, a_q}) : div_shl;
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= {1'b0, mul_sum[XLEN:1]};
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        S_DONE:  result_q <= res_c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_exe_muldiv.sv
// Self-checking bench for the RV64M multiply/divide unit: directed corner cases
// plus randomized ops against an arithmetic reference model.
module tb_ysyx_041461_exe_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        muldiv_valid;
  logic [3:0]  muldiv_op;
  logic [63:0] muldiv_src1, muldiv_src2;
  logic        muldiv_flush;
  logic        muldiv_busy, muldiv_done;
  logic [63:0] muldiv_result;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  ysyx_041461_exe_muldiv dut (
    .clk           (clk),
    .rst           (rst),
    .muldiv_valid  (muldiv_valid),
    .muldiv_op     (muldiv_op),
    .muldiv_src1   (muldiv_src1),
    .muldiv_src2   (muldiv_src2),
    .muldiv_flush  (muldiv_flush),
    .muldiv_busy   (muldiv_busy),
    .muldiv_done   (muldiv_done),
    .muldiv_result (muldiv_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural RV64M result, computed with plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic signed [63:0]  sa, sb, sr;
    logic signed [31:0]  a32, b32, r32;
    logic [31:0]         ua32, ub32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    case (op)
      4'd0: begin pu = {64'b0, a} * {64'b0, b}; return pu[63:0]; end
      4'd1: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return ps[127:64]; end
      4'd2: begin pu = {{64{a[63]}}, a} * {64'b0, b}; return pu[127:64]; end
      4'd3: begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
      4'd4: begin
        if (b == 0) return '1;
        if (a == MIN64 && b == '1) return a;
        sr = sa / sb; return sr;
      end
      4'd5: return (b == 0) ? '1 : a / b;
      4'd6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == '1) return '0;
        sr = sa % sb; return sr;
      end
      4'd7: return (b == 0) ? a : a % b;
      4'd8: begin r32 = a32 * b32; return sx(r32); end
      4'd9: begin
        if (b32 == 0) return '1;
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return sx(a32);
        r32 = a32 / b32; return sx(r32);
      end
      4'd10: return (ub32 == 0) ? '1 : sx(ua32 / ub32);
      4'd11: begin
        if (b32 == 0) return sx(a32);
        if (a32 == 32'sh8000_0000 && b32 == -32'sd1) return '0;
        r32 = a32 % b32; return sx(r32);
      end
      4'd12: return (ub32 == 0) ? sx(ua32) : sx(ua32 % ub32);
      default: return '0;
    endcase
  endfunction

  function automatic bit is_special(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd4, 4'd6:   return (b == 0) || (a == MIN64 && b == '1);
      4'd5, 4'd7:   return b == 0;
      4'd9, 4'd11:  return (b[31:0] == 0) || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      4'd10, 4'd12: return b[31:0] == 0;
      4'd13, 4'd14, 4'd15: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  // Issue one op at the current cycle, follow it to done and check timing and result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    int  lat, exp_lat, stall_bad;
    bit  seen;
    exp_lat = is_special(op, a, b) ? 1 : 65;
    muldiv_valid = 1'b1; muldiv_op = op; muldiv_src1 = a; muldiv_src2 = b;
    #1;
    check({tag, " busy@accept"}, 64'(muldiv_busy), 64'd1);
    @(posedge clk); #1;
    muldiv_valid = 1'b0;
    muldiv_src1 = {$urandom, $urandom}; muldiv_src2 = {$urandom, $urandom};
    muldiv_op = 4'($urandom_range(0, 15));
    lat = 1; seen = 0; stall_bad = 0;
    while (!seen && lat <= 80) begin
      #1;
      if (muldiv_done) seen = 1;
      else begin
        if (!muldiv_busy) stall_bad++;
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, " latency"}, seen ? 64'(lat) : 64'hDEAD, 64'(exp_lat));
    check({tag, " result"}, muldiv_result, exp);
    check({tag, " busy@done"}, 64'(muldiv_busy), 64'd0);
    check({tag, " busy stall"}, 64'(stall_bad), 64'd0);
    @(posedge clk); #2;
    check({tag, " done 1-cycle"}, 64'(muldiv_done), 64'd0);
    check({tag, " result hold"}, muldiv_result, exp);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [63:0] r_a, r_b;
    rst = 1'b1; muldiv_valid = 1'b0; muldiv_op = '0;
    muldiv_src1 = '0; muldiv_src2 = '0; muldiv_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(muldiv_busy), 64'd0);
    check("reset done", 64'(muldiv_done), 64'd0);
    check("reset result", muldiv_result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("MUL 3*-5",     4'd0, 64'd3, -64'sd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("MULHU -1*-1",  4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("MULH -1*-1",   4'd1, '1, '1, 64'd0);
    run_op("DIV 7/0",      4'd4, 64'd7, 64'd0, '1);
    run_op("REM 7/0",      4'd6, 64'd7, 64'd0, 64'd7);
    run_op("DIV min/-1",   4'd4, MIN64, '1, MIN64);
    run_op("REM min/-1",   4'd6, MIN64, '1, 64'd0);
    run_op("REMW -7/2",    4'd11, 64'h0000_0000_FFFF_FFF9, 64'd2, '1);
    run_op("DIVUW",        4'd10, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF);
    run_op("DIV -7/2",     4'd4, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("REM -7/2",     4'd6, -64'sd7, 64'd2, '1);
    run_op("MULW",         4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("RSVD",         4'd13, 64'd5, 64'd9, 64'd0);

    // Flush a DIVU at T+10, then accept a MUL at T+11.
    muldiv_valid = 1'b1; muldiv_op = 4'd5; muldiv_src1 = 64'd100; muldiv_src2 = 64'd7;
    @(posedge clk); #1;
    muldiv_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    muldiv_flush = 1'b1;
    #1;
    check("flush done", 64'(muldiv_done), 64'd0);
    @(posedge clk); #1;
    muldiv_flush = 1'b0;
    #1;
    check("flush idle busy", 64'(muldiv_busy), 64'd0);
    check("flush idle done", 64'(muldiv_done), 64'd0);
    run_op("MUL 6*7 post-flush", 4'd0, 64'd6, 64'd7, 64'd42);

    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a = {$urandom, $urandom};
      r_b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: r_b = '0;
        1: begin r_a = MIN64; r_b = '1; end
        2: begin r_a = 64'hFFFF_FFFF_8000_0000; r_b = '1; end
        3: begin r_a = 64'($urandom_range(0, 1000)); r_b = 64'($urandom_range(1, 50));
                 if ($urandom_range(0, 1) == 1) r_a = -r_a; end
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b, ref_model(r_op, r_a, r_b));
    end

    // Reset during CALC returns the outputs to their reset values at once.
    muldiv_valid = 1'b1; muldiv_op = 4'd0; muldiv_src1 = 64'd11; muldiv_src2 = 64'd13;
    @(posedge clk); #1;
    muldiv_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midcalc rst busy", 64'(muldiv_busy), 64'd0);
    check("midcalc rst done", 64'(muldiv_done), 64'd0);
    check("midcalc rst result", muldiv_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("MUL after rst", 4'd0, 64'd11, 64'd13, 64'd143);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
